// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  localparam int DEF_ADDR_W          = 8;
  localparam int DEF_DATA_W          = 8;
  localparam int DEF_WORDS_PER_BLOCK = 4;
  localparam int DEF_NUM_SETS        = 8;

  function automatic int offset_w(input int words_per_block);
    return $clog2(words_per_block);
  endfunction

  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int words_per_block, input int num_sets);
    return addr_w - $clog2(words_per_block) - $clog2(num_sets);
  endfunction

  function automatic int block_w(input int data_w, input int words_per_block);
    return data_w * words_per_block;
  endfunction

endpackage

// File: rtl/dcache_ctrl.sv
// Miss-handling FSM: sequences victim write-back, block allocate and line update,
// and drives the block-wide memory request port.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int TAG_W   = 3,
  parameter int INDEX_W = 3,
  parameter int BLOCK_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic                     hit,
  input  logic                     victim_dirty,
  input  logic [TAG_W-1:0]         tag,
  input  logic [TAG_W-1:0]         victim_tag,
  input  logic [INDEX_W-1:0]       index,
  input  logic [BLOCK_W-1:0]       victim_block,
  input  logic                     mem_busywait,
  output state_t                   state,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [TAG_W+INDEX_W-1:0] mem_address,
  output logic [BLOCK_W-1:0]       mem_writedata
);

  state_t next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Requests are decoded from the state alone, so an async reset drops them at once.
  always_comb begin
    next_state    = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    unique case (state)
      IDLE: begin
        if (req && !hit) begin
          next_state = victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {victim_tag, index};
        mem_writedata = victim_block;
        if (!mem_busywait) begin
          next_state = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_read    = 1'b1;
        mem_address = {tag, index};
        if (!mem_busywait) begin
          next_state = UPDATE;
        end
      end
      UPDATE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU port and block memory.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache
  import dcache_pkg::*;
#(
  parameter int  ADDR_W          = DEF_ADDR_W,
  parameter int  DATA_W          = DEF_DATA_W,
  parameter int  WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int  NUM_SETS        = DEF_NUM_SETS,
  localparam int OFFSET_W        = offset_w(WORDS_PER_BLOCK),
  localparam int INDEX_W         = index_w(NUM_SETS),
  localparam int TAG_W           = tag_w(ADDR_W, WORDS_PER_BLOCK, NUM_SETS),
  localparam int BLOCK_W         = block_w(DATA_W, WORDS_PER_BLOCK)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       READ,
  input  logic                       WRITE,
  input  logic [ADDR_W-1:0]          ADDRESS,
  input  logic [DATA_W-1:0]          WRITEDATA,
  output logic [DATA_W-1:0]          READDATA,
  output logic                       BUSYWAIT,
  output logic                       MEM_READ,
  output logic                       MEM_WRITE,
  output logic [ADDR_W-OFFSET_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]         MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]         MEM_READDATA,
  input  logic                       MEM_BUSYWAIT,
  output logic [15:0]                HIT_COUNT,
  output logic [15:0]                MISS_COUNT
);

  logic [OFFSET_W-1:0] offset;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;

  assign offset = ADDRESS[OFFSET_W-1:0];
  assign index  = ADDRESS[OFFSET_W +: INDEX_W];
  assign tag    = ADDRESS[ADDR_W-1 -: TAG_W];

  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  logic [TAG_W-1:0]    tag_arr  [NUM_SETS];
  logic [BLOCK_W-1:0]  data_arr [NUM_SETS];

  state_t            state;
  logic              req;
  logic              hit;
  logic              write_hit;
  logic              fill;
  logic [DATA_W-1:0] hit_word;

  assign req       = READ | WRITE;
  assign hit       = valid[index] && (tag_arr[index] == tag);
  assign write_hit = (state == IDLE) && WRITE && hit;
  assign fill      = (state == UPDATE);
  assign hit_word  = data_arr[index][offset*DATA_W +: DATA_W];

  // WRITE wins over READ, so a simultaneous strobe never returns load data.
  assign READDATA = (READ && !WRITE && hit) ? hit_word : '0;
  assign BUSYWAIT = RESET & req & ((state != IDLE) | ~hit);

  dcache_ctrl #(
    .TAG_W   (TAG_W),
    .INDEX_W (INDEX_W),
    .BLOCK_W (BLOCK_W)
  ) u_ctrl (
    .clk           (CLK),
    .rst_n         (RESET),
    .req           (req),
    .hit           (hit),
    .victim_dirty  (valid[index] & dirty[index]),
    .tag           (tag),
    .victim_tag    (tag_arr[index]),
    .index         (index),
    .victim_block  (data_arr[index]),
    .mem_busywait  (MEM_BUSYWAIT),
    .state         (state),
    .mem_read      (MEM_READ),
    .mem_write     (MEM_WRITE),
    .mem_address   (MEM_ADDRESS),
    .mem_writedata (MEM_WRITEDATA)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (write_hit) begin
      dirty[index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid bits gate every use of them.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_arr[index]  <= tag;
      data_arr[index] <= MEM_READDATA;
    end else if (write_hit) begin
      data_arr[index][offset*DATA_W +: DATA_W] <= WRITEDATA;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        after_fill;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  // The cycle right after UPDATE completes the missed request and is not a fresh hit.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      after_fill <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      after_fill <= fill;
      if ((state == IDLE) && req && hit && !after_fill && (hit_count != 16'hFFFF)) begin
        hit_count <= hit_count + 16'd1;
      end
      if ((state == IDLE) && req && !hit && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end

  assign HIT_COUNT  = hit_count;
  assign MISS_COUNT = miss_count;
`else
  assign HIT_COUNT  = '0;
  assign MISS_COUNT = '0;
`endif

endmodule

// File: doc/dcache.md
# dcache

Parametrised direct-mapped, write-back, write-allocate data cache between the `cpu` load/store port and `data_memory`. It is the next stage of the memory hierarchy. It presents the same READ/WRITE/ADDRESS/WRITEDATA/READDATA/BUSYWAIT handshake to the CPU that `data_memory` does today. Hits are served without stalling the CPU; only misses pay the multi-cycle block transfer to `data_memory`, which is widened to one whole block per access.

## Interface
- ADDR_W, 8, CPU byte-address width
- DATA_W, 8, CPU word width
- WORDS_PER_BLOCK, 4, words per line (power of 2, ≥2)
- NUM_SETS, 8, number of lines (power of 2)
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-low reset
- READ, WRITE  in  1  CPU request strobes, held until BUSYWAIT low
- ADDRESS  in  ADDR_W  CPU word address
- WRITEDATA  in  DATA_W  store data
- READDATA  out  DATA_W  load data
- BUSYWAIT  out  1  CPU stall
- MEM_READ, MEM_WRITE  out  1  block requests to memory
- MEM_ADDRESS  out  ADDR_W−log2(WORDS_PER_BLOCK)  block address
- MEM_WRITEDATA  out  DATA_W·WORDS_PER_BLOCK  victim block
- MEM_READDATA  in  DATA_W·WORDS_PER_BLOCK  fill block
- MEM_BUSYWAIT  in  1  memory stall
- HIT_COUNT, MISS_COUNT  out  16  statistics (see Configuration)

## Operation
- Address split: OFFSET = low log2(WORDS_PER_BLOCK) bits; INDEX = next log2(NUM_SETS) bits; TAG = remaining upper bits. Word 0 of a block occupies MEM_READDATA/MEM_WRITEDATA bits [DATA_W−1:0].
- Per line: valid, dirty, tag, block data.
- hit = valid[INDEX] & (tag[INDEX]==TAG).
- FSM states and transitions:
  - IDLE: on a request with hit, stay. On a miss with a dirty victim, go to WRITEBACK. On a miss with a clean or invalid victim, go to ALLOCATE.
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={victim tag, INDEX}, MEM_WRITEDATA=victim block. Held until MEM_BUSYWAIT=0 at a rising edge, then go to ALLOCATE.
  - ALLOCATE: MEM_READ=1, MEM_ADDRESS={TAG, INDEX}. Held until MEM_BUSYWAIT=0 at a rising edge, then go to UPDATE.
  - UPDATE: one cycle. Writes MEM_READDATA into the line and sets valid=1, dirty=0, tag=TAG. Goes to IDLE; the request then completes as a hit.
- Read hit: READDATA = line word[OFFSET], combinational. READDATA is 0 when there is no read hit.
- Write hit: at the rising edge, word[OFFSET] ← WRITEDATA and dirty ← 1.
- READ and WRITE both high is illegal; WRITE takes priority.
- The cache never issues MEM_READ and MEM_WRITE together.
- Reset (async, low): all valid and dirty bits cleared, FSM to IDLE. Dirty data in flight is discarded. Data and tag arrays are not required to be cleared.

## Timing
- Output values during reset: BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0, counters=0.
- BUSYWAIT = (READ|WRITE) & (state≠IDLE | ~hit), combinational.
- Hit latency is 0 stall cycles: BUSYWAIT stays low and the CPU advances at the same edge.
- Clean miss: ALLOCATE lasts (memory latency) cycles, then 1 UPDATE cycle, then the hit cycle.
- Dirty miss: adds WRITEBACK (memory latency) cycles before ALLOCATE.
- The MEM_* request is asserted from the first cycle of its state. MEM_ADDRESS and MEM_WRITEDATA are stable while the request is high.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE drops the MEM_* request immediately (asynchronously).

## Configuration
- DCACHE_STATS_EN defined:
  - HIT_COUNT increments once per request that completes without a miss.
  - MISS_COUNT increments once per miss, at the IDLE→WRITEBACK/ALLOCATE transition.
  - Both counters are 16-bit and saturate at 0xFFFF.
- DCACHE_STATS_EN undefined: no counter logic is built; HIT_COUNT and MISS_COUNT are tied to 0.

## Structure
- `dcache_pkg` holds:
  - the state enum (IDLE, WRITEBACK, ALLOCATE, UPDATE);
  - localparam helpers for OFFSET_W, INDEX_W, TAG_W and BLOCK_W derived from the parameters.
- One sub-module, `dcache_ctrl`: the FSM plus MEM_* request generation. The storage arrays and hit logic stay in `dcache`.

## Test plan
All scenarios use default parameters and a memory model with 5-cycle block latency.
- Cold read at 0x8C (INDEX=3, TAG=4) → BUSYWAIT high. MEM_READ with MEM_ADDRESS=0x23 for 5 cycles, then UPDATE, then READDATA=word[0] of the block and BUSYWAIT low. Repeating the read gives 0 stall cycles.
- Write 0x04 to 0x8C after the fill → no MEM_* activity. A read of 0x8C returns 0x04; dirty[3]=1.
- Read 0x0C (INDEX=3, TAG=0) with line 3 dirty → MEM_WRITE with MEM_ADDRESS=0x23 and MEM_WRITEDATA containing 0x04 in bits [7:0]. Then MEM_READ with MEM_ADDRESS=0x03; never both high together.
- Write miss at 0x8A → allocate block 0x22, then merge the store. A later read of 0x8A returns the stored value and MISS_COUNT increments by 1.
- RESET pulsed low during ALLOCATE → MEM_READ drops asynchronously and the FSM returns to IDLE. A read of the previously filled 0x8C misses again.
- With DCACHE_STATS_EN: 3 hits and 2 misses → HIT_COUNT=3, MISS_COUNT=2. Without the macro, both read 0.
